rca_share_ctrl: RTL and testbench

- Shares a single rca4 4-bit adder slice between two requesters.
- Sequences each accepted request over NIBBLES cycles, least-significant nibble first, to form a 4*NIBBLES-bit sum.
- Selects requesters round-robin, uses valid/ready on both the request and result sides, and holds a carry register between nibbles.
- Sits between the operand sources and the result consumer; it is the only client of its rca4 instance.

---
 rtl/rca_share_ctrl.sv | 137 +++++++++++++
 tb/tb_rca_share_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca_share_ctrl.sv
// Time-shares one 4-bit ripple-carry slice between two requesters, one nibble per cycle, LSB first.
// Result appears NIBBLES edges after the accept; DONE holds the result until res_ready.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module rca_share_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_ci,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_ci,
  output logic         req1_ready,
  output logic         res_valid,
  output logic [W-1:0] res_sum,
  output logic         res_co,
  output logic         res_id,
  input  logic         res_ready
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NIBBLES - 1);

  state_t       state;
  logic         last;
  logic [3:0]   cnt;
  logic         carry;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  logic         gnt_any;
  logic         gnt_id;
  logic         accept;
  logic [3:0]   nib_a;
  logic [3:0]   nib_b;
  logic [3:0]   nib_s;
  logic         nib_co;

  // When both ask, the one not served last time wins.
  assign gnt_any    = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign accept     = (state == IDLE) & ~rst & gnt_any;
  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;

  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt == 4'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  rca4 u_rca4 (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= 4'd0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_co    <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= gnt_id ? req1_a  : req0_a;
            b_q    <= gnt_id ? req1_b  : req0_b;
            carry  <= gnt_id ? req1_ci : req0_ci;
            res_id <= gnt_id;
            last   <= gnt_id;
            cnt    <= 4'd0;
            state  <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == 4'(i)) res_sum[4*i +: 4] <= nib_s;
          end
          carry <= nib_co;
          cnt   <= cnt + 4'd1;
          if (cnt == LAST) begin
            res_co    <= nib_co;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_share_ctrl.sv
// Directed bench for rca_share_ctrl: a NIBBLES=4 instance for the main scenarios, a NIBBLES=1 instance for the single-slice case.

module tb_rca_share_ctrl;
  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ci, req1_ci;
  logic        res_valid, res_co, res_id, res_ready;
  logic [15:0] res_sum;

  logic        n1_req0_valid, n1_req1_valid, n1_req0_ready, n1_req1_ready;
  logic [3:0]  n1_req0_a, n1_req0_b, n1_req1_a, n1_req1_b;
  logic        n1_req0_ci, n1_req1_ci;
  logic        n1_res_valid, n1_res_co, n1_res_id, n1_res_ready;
  logic [3:0]  n1_res_sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rca_share_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_co(res_co), .res_id(res_id), .res_ready(res_ready)
  );

  rca_share_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(n1_req0_valid), .req0_a(n1_req0_a), .req0_b(n1_req0_b), .req0_ci(n1_req0_ci), .req0_ready(n1_req0_ready),
    .req1_valid(n1_req1_valid), .req1_a(n1_req1_a), .req1_b(n1_req1_b), .req1_ci(n1_req1_ci), .req1_ready(n1_req1_ready),
    .res_valid(n1_res_valid), .res_sum(n1_res_sum), .res_co(n1_res_co), .res_id(n1_res_id), .res_ready(n1_res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_grant(output logic g);
    int n = 0;
    while (!(req0_ready | req1_ready) && n < 60) begin
      step();
      n++;
    end
    check("gnt_seen", 64'(req0_ready | req1_ready), 64'd1);
    g = req1_ready;
  endtask

  logic [16:0] q0[$];
  logic [16:0] q1[$];

  initial begin
    int lat;
    int t_gnt;
    int done;
    int n;
    logic g;
    logic [16:0] e;

    rst = 1'b1; res_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_ci = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ci = 1'b0;
    n1_req0_valid = 1'b0; n1_req0_a = '0; n1_req0_b = '0; n1_req0_ci = 1'b0;
    n1_req1_valid = 1'b0; n1_req1_a = '0; n1_req1_b = '0; n1_req1_ci = 1'b0;
    n1_res_ready = 1'b1;
    t_gnt = 0;

    // Reset values, with a request already pending
    step(); step();
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_sum", 64'(res_sum), 64'd0);
    check("rst_co", 64'(res_co), 64'd0);
    check("rst_id", 64'(res_id), 64'd0);
    check("rst_rdy0", 64'(req0_ready), 64'd0);

    // Carry ripples through all nibbles; accepted on first edge after reset
    rst = 1'b0;
    #1;
    check("t1_rdy0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_ci = 1'b1;
    wait_result(lat);
    check("t1_lat", 64'(lat), 64'd4);
    check("t1_sum", 64'(res_sum), 64'h0000);
    check("t1_co", 64'(res_co), 64'd1);
    check("t1_id", 64'(res_id), 64'd0);
    step();
    check("t1_vld_drop", 64'(res_valid), 64'd0);

    // Fairness with both requesters valid from reset
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111; req0_ci = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h0F01; req1_ci = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      check("fair_gnt", 64'(g), 64'(k % 2));
      if (k == 2) check("issue_interval", 64'(cyc - t_gnt), 64'd6);
      t_gnt = cyc;
      step();
      wait_result(lat);
      check("fair_lat", 64'(lat), 64'd4);
      check("fair_id", 64'(res_id), 64'(k % 2));
      check("fair_sum", 64'({res_co, res_sum}), (k % 2 == 0) ? 64'h02345 : 64'h01001);
      step();
    end

    // Backpressure in DONE
    req1_valid = 1'b0;
    req0_a = 16'h8000; req0_b = 16'h8000; req0_ci = 1'b1;
    res_ready = 1'b0;
    #1;
    wait_grant(g);
    check("bp_gnt", 64'(g), 64'd0);
    step();
    req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0003; req1_ci = 1'b0;
    req0_a = 16'h0F0F;
    wait_result(lat);
    check("bp_lat", 64'(lat), 64'd4);
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", 64'({res_valid, res_sum, res_co, res_id, req0_ready, req1_ready}),
            64'({1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0}));
      step();
    end
    res_ready = 1'b1;
    step();
    check("bp_vld_drop", 64'(res_valid), 64'd0);
    check("bp_next_gnt", 64'({req0_ready, req1_ready}), 64'b01);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(lat);
    check("bp2_sum", 64'({res_co, res_sum}), 64'h00008);
    check("bp2_id", 64'(res_id), 64'd1);
    step();

    // Reset in the middle of an ADD
    req1_valid = 1'b1; req1_a = 16'h1111; req1_b = 16'h2222; req1_ci = 1'b0;
    #1;
    wait_grant(g);
    step();
    req1_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    check("midrst_out", 64'({res_valid, res_sum, res_co, res_id, req0_ready, req1_ready}), 64'd0);
    step();
    check("midrst_hold", 64'(res_valid), 64'd0);
    req0_valid = 1'b1; req0_a = 16'h7000; req0_b = 16'h9000; req0_ci = 1'b0;
    req1_valid = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_ptr", 64'({req0_ready, req1_ready}), 64'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(lat);
    check("midrst_lat", 64'(lat), 64'd4);
    check("midrst_res", 64'({res_co, res_sum, res_id}), 64'({1'b1, 16'h0000, 1'b0}));
    step();

    // Single-slice instance
    n1_req0_valid = 1'b1; n1_req0_a = 4'hF; n1_req0_b = 4'hF; n1_req0_ci = 1'b1;
    #1;
    check("n1_rdy", 64'(n1_req0_ready), 64'd1);
    step();
    n1_req0_valid = 1'b0; n1_req0_a = 4'h0;
    lat = 0;
    while (!n1_res_valid && lat < 20) begin
      step();
      lat++;
    end
    check("n1_lat", 64'(lat), 64'd1);
    check("n1_res", 64'({n1_res_co, n1_res_sum, n1_res_id}), 64'({1'b1, 4'hF, 1'b0}));
    step();

    // Random traffic against a+b+ci, per-requester order
    done = 0;
    n = 0;
    while (done < 40 && n < 5000) begin
      @(negedge clk);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = 16'($urandom); req0_b = 16'($urandom); req0_ci = 1'($urandom_range(0, 1));
      req1_a = 16'($urandom); req1_b = 16'($urandom); req1_ci = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (req0_valid && req0_ready) q0.push_back({1'b0, req0_a} + {1'b0, req0_b} + 17'(req0_ci));
      if (req1_valid && req1_ready) q1.push_back({1'b0, req1_a} + {1'b0, req1_b} + 17'(req1_ci));
      if (res_valid && res_ready) begin
        check("rand_inflight", 64'(q0.size() + q1.size()), 64'd1);
        if (res_id == 1'b0 && q0.size() > 0) e = q0.pop_front();
        else if (res_id == 1'b1 && q1.size() > 0) e = q1.pop_front();
        else e = 17'h1FFFF;
        check("rand_sum", 64'({res_co, res_sum}), 64'(e));
        done++;
      end
      n++;
    end
    check("rand_done", 64'(done), 64'd40);
    check("rand_left", 64'(q0.size() + q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
